dm_access_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that lets four processing cores share a single read/write port of the 16-bit data memory.
- Serialises core requests so no two cores write or read the RAM in the same cycle.
- Holds all cores off while the external loader (load_mode) owns the memory.
- Sits between the core load/store units and one memory port: write enable, address, data in, registered data out with 1-cycle read latency.

---
 rtl/dm_access_if.sv | 48 ++++
 rtl/dm_access_arbiter.sv | 129 ++++++++++++
 tb/tb_dm_access_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_if.sv
// Bus bundle between the four core load/store units, the arbiter and the
// single data-memory port.
interface dm_access_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              load_mode;
  logic              req1, req2, req3, req4;
  logic              we1, we2, we3, we4;
  logic [ADDR_W-1:0] addr1, addr2, addr3, addr4;
  logic [DATA_W-1:0] data_in1, data_in2, data_in3, data_in4;
  logic              gnt1, gnt2, gnt3, gnt4;
  logic              rvalid1, rvalid2, rvalid3, rvalid4;
  logic [DATA_W-1:0] rdata1, rdata2, rdata3, rdata4;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  load_mode,
    input  req1, req2, req3, req4,
    input  we1, we2, we3, we4,
    input  addr1, addr2, addr3, addr4,
    input  data_in1, data_in2, data_in3, data_in4,
    input  mem_data_out,
    output gnt1, gnt2, gnt3, gnt4,
    output rvalid1, rvalid2, rvalid3, rvalid4,
    output rdata1, rdata2, rdata3, rdata4,
    output mem_write_en, mem_addr, mem_data_in,
    output busy
  );

  modport master (
    output load_mode,
    output req1, req2, req3, req4,
    output we1, we2, we3, we4,
    output addr1, addr2, addr3, addr4,
    output data_in1, data_in2, data_in3, data_in4,
    output mem_data_out,
    input  gnt1, gnt2, gnt3, gnt4,
    input  rvalid1, rvalid2, rvalid3, rvalid4,
    input  rdata1, rdata2, rdata3, rdata4,
    input  mem_write_en, mem_addr, mem_data_in,
    input  busy
  );
endinterface

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter serialising four cores onto one data-memory port
// (1-cycle registered read latency); cores are held off while load_mode is high.
module dm_access_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  dm_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [1:0]        cur_idx;
  logic              cur_we;
  logic [3:0]        gnt_vec;
  logic [3:0]        rvalid_vec;
  logic              busy_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DATA_W-1:0] rdata_q [4];

  logic [3:0]        req_vec;
  logic [3:0]        we_vec;
  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];
  logic [1:0]        cand;
  logic [1:0]        sel_idx;
  logic              sel_found;

  assign req_vec     = {bus.req4, bus.req3, bus.req2, bus.req1};
  assign we_vec      = {bus.we4, bus.we3, bus.we2, bus.we1};
  assign addr_arr[0] = bus.addr1;
  assign addr_arr[1] = bus.addr2;
  assign addr_arr[2] = bus.addr3;
  assign addr_arr[3] = bus.addr4;
  assign data_arr[0] = bus.data_in1;
  assign data_arr[1] = bus.data_in2;
  assign data_arr[2] = bus.data_in3;
  assign data_arr[3] = bus.data_in4;

  // Search starts just after the last winner; k = 4 wraps back to it last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!sel_found && req_vec[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 2'd3;
      cur_idx    <= 2'd0;
      cur_we     <= 1'b0;
      gnt_vec    <= '0;
      rvalid_vec <= '0;
      busy_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      for (int i = 0; i < 4; i++) rdata_q[i] <= '0;
    end else begin
      gnt_vec    <= '0;
      rvalid_vec <= '0;
      case (state)
        IDLE: begin
          if (!bus.load_mode && sel_found) begin
            rr_ptr           <= sel_idx;
            cur_idx          <= sel_idx;
            cur_we           <= we_vec[sel_idx];
            mem_we_q         <= we_vec[sel_idx];
            mem_addr_q       <= addr_arr[sel_idx];
            mem_data_q       <= data_arr[sel_idx];
            gnt_vec[sel_idx] <= 1'b1;
            busy_q           <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we_q <= 1'b0;
          if (cur_we) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata_q[cur_idx]    <= bus.mem_data_out;
          rvalid_vec[cur_idx] <= 1'b1;
          busy_q              <= 1'b0;
          state               <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt1         = gnt_vec[0];
  assign bus.gnt2         = gnt_vec[1];
  assign bus.gnt3         = gnt_vec[2];
  assign bus.gnt4         = gnt_vec[3];
  assign bus.rvalid1      = rvalid_vec[0];
  assign bus.rvalid2      = rvalid_vec[1];
  assign bus.rvalid3      = rvalid_vec[2];
  assign bus.rvalid4      = rvalid_vec[3];
  assign bus.rdata1       = rdata_q[0];
  assign bus.rdata2       = rdata_q[1];
  assign bus.rdata3       = rdata_q[2];
  assign bus.rdata4       = rdata_q[3];
  assign bus.mem_write_en = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_in  = mem_data_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/timing model.
module tb_dm_access_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_access_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dm_access_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        req_d  [4];
  logic        we_d   [4];
  logic [15:0] addr_d [4];
  logic [15:0] data_d [4];
  logic        load_mode_d;

  assign bus.load_mode = load_mode_d;
  assign bus.req1 = req_d[0];
  assign bus.req2 = req_d[1];
  assign bus.req3 = req_d[2];
  assign bus.req4 = req_d[3];
  assign bus.we1 = we_d[0];
  assign bus.we2 = we_d[1];
  assign bus.we3 = we_d[2];
  assign bus.we4 = we_d[3];
  assign bus.addr1 = addr_d[0];
  assign bus.addr2 = addr_d[1];
  assign bus.addr3 = addr_d[2];
  assign bus.addr4 = addr_d[3];
  assign bus.data_in1 = data_d[0];
  assign bus.data_in2 = data_d[1];
  assign bus.data_in3 = data_d[2];
  assign bus.data_in4 = data_d[3];

  logic [3:0]  gnt_v;
  logic [3:0]  rvalid_v;
  logic [15:0] rdata_a [4];
  assign gnt_v      = {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1};
  assign rvalid_v   = {bus.rvalid4, bus.rvalid3, bus.rvalid2, bus.rvalid1};
  assign rdata_a[0] = bus.rdata1;
  assign rdata_a[1] = bus.rdata2;
  assign rdata_a[2] = bus.rdata3;
  assign rdata_a[3] = bus.rdata4;

  // Memory attached to the port: synchronous write, registered read.
  logic [15:0] tbmem [logic [15:0]];
  int we_count;
  always @(posedge clk) begin
    logic [15:0] rd;
    rd = tbmem.exists(bus.mem_addr) ? tbmem[bus.mem_addr] : 16'h0000;
    if (bus.mem_write_en) begin
      tbmem[bus.mem_addr] = bus.mem_data_in;
      we_count = we_count + 1;
    end
    bus.mem_data_out <= rd;
  end

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_d[i]  = 1'b0;
      we_d[i]   = 1'b0;
      addr_d[i] = 16'h0000;
      data_d[i] = 16'h0000;
    end
    load_mode_d = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_d[i] = 1'b1;
      we_d[i]  = 1'b1;
      addr_d[i] = 16'h0300 + 16'(i);
    end
    rst_n = 1'b0;
    step();
    step();
    checks++; if (gnt_v !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt_v); end
    checks++; if (rvalid_v !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid_v); end
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_write_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.mem_addr !== 16'h0000 || bus.mem_data_in !== 16'h0000) begin errors++; $display("FAIL reset_mem_bus: got addr %h data %h expected 0000 0000", bus.mem_addr, bus.mem_data_in); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rdata_a[i] !== 16'h0000) begin errors++; $display("FAIL reset_rdata%0d: got %h expected 0000", i + 1, rdata_a[i]); end
    end
    rst_n = 1'b1;
    step();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt_v); end
    clear_inputs();
    repeat (3) step();
  endtask

  task automatic test_single_read();
    clear_inputs();
    apply_reset();
    tbmem[16'h0010] = 16'hBEEF;
    req_d[1] = 1'b1; we_d[1] = 1'b0; addr_d[1] = 16'h0010;
    step();
    checks++; if (gnt_v !== 4'b0010) begin errors++; $display("FAIL sread_gnt: got %b expected 0010", gnt_v); end
    checks++; if (bus.mem_addr !== 16'h0010 || bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL sread_issue: got addr %h we %b expected 0010 0", bus.mem_addr, bus.mem_write_en); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sread_busy: got %b expected 1", bus.busy); end
    req_d[1] = 1'b0;
    step();
    checks++; if (gnt_v !== 4'b0000 || rvalid_v !== 4'b0000) begin errors++; $display("FAIL sread_wait: got gnt %b rvalid %b expected 0000 0000", gnt_v, rvalid_v); end
    step();
    checks++; if (rvalid_v !== 4'b0010) begin errors++; $display("FAIL sread_rvalid: got %b expected 0010", rvalid_v); end
    checks++; if (rdata_a[1] !== 16'hBEEF) begin errors++; $display("FAIL sread_rdata: got %h expected beef", rdata_a[1]); end
    step();
    checks++; if (rvalid_v !== 4'b0000 || rdata_a[1] !== 16'hBEEF || bus.busy !== 1'b0) begin errors++; $display("FAIL sread_after: got rvalid %b rdata %h busy %b expected 0000 beef 0", rvalid_v, rdata_a[1], bus.busy); end
  endtask

  task automatic test_write_read();
    clear_inputs();
    apply_reset();
    we_count = 0;
    req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 16'h0005; data_d[0] = 16'h1234;
    step();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b expected 0001", gnt_v); end
    checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_addr !== 16'h0005 || bus.mem_data_in !== 16'h1234) begin errors++; $display("FAIL wr_port: got we %b addr %h data %h expected 1 0005 1234", bus.mem_write_en, bus.mem_addr, bus.mem_data_in); end
    req_d[0] = 1'b0;
    step();
    checks++; if (bus.mem_write_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL wr_done: got we %b busy %b expected 0 0", bus.mem_write_en, bus.busy); end
    req_d[2] = 1'b1; we_d[2] = 1'b0; addr_d[2] = 16'h0005;
    step();
    checks++; if (gnt_v !== 4'b0100) begin errors++; $display("FAIL rd_gnt: got %b expected 0100", gnt_v); end
    req_d[2] = 1'b0;
    step();
    step();
    checks++; if (rvalid_v !== 4'b0100 || rdata_a[2] !== 16'h1234) begin errors++; $display("FAIL rd_data: got rvalid %b rdata %h expected 0100 1234", rvalid_v, rdata_a[2]); end
    checks++; if (we_count !== 1) begin errors++; $display("FAIL wr_pulses: got %0d expected 1", we_count); end
  endtask

  task automatic test_contention();
    int order[$];
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_d[i]  = 1'b1;
      we_d[i]   = 1'b1;
      addr_d[i] = 16'h0200 + 16'(i);
      data_d[i] = 16'hA000 + 16'(i);
    end
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if ($countones(gnt_v) > 1) begin errors++; $display("FAIL cont_onehot: got %b expected at most one bit", gnt_v); end
      for (int i = 0; i < 4; i++) if (gnt_v[i]) order.push_back(i + 1);
    end
    checks++; if (order.size() !== 5) begin errors++; $display("FAIL cont_count: got %0d expected 5", order.size()); end
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      checks++; if (order[k] !== (k % 4) + 1) begin errors++; $display("FAIL cont_order%0d: got %0d expected %0d", k, order[k], (k % 4) + 1); end
    end
    clear_inputs();
    repeat (3) step();
  endtask

  task automatic test_load_mode();
    clear_inputs();
    apply_reset();
    tbmem[16'h0020] = 16'hCAFE;
    req_d[2] = 1'b1; we_d[2] = 1'b0; addr_d[2] = 16'h0020;
    step();
    checks++; if (gnt_v !== 4'b0100) begin errors++; $display("FAIL lm_gnt3: got %b expected 0100", gnt_v); end
    load_mode_d = 1'b1;
    req_d[2] = 1'b0;
    req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 16'h0030; data_d[0] = 16'h5555;
    step();
    step();
    checks++; if (rvalid_v !== 4'b0100 || rdata_a[2] !== 16'hCAFE) begin errors++; $display("FAIL lm_rvalid3: got rvalid %b rdata %h expected 0100 cafe", rvalid_v, rdata_a[2]); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (gnt_v !== 4'b0000) begin errors++; $display("FAIL lm_hold: got %b expected 0000", gnt_v); end
    end
    load_mode_d = 1'b0;
    step();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL lm_release: got %b expected 0001", gnt_v); end
    req_d[0] = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    apply_reset();
    tbmem[16'h0040] = 16'h7777;
    req_d[3] = 1'b1; we_d[3] = 1'b0; addr_d[3] = 16'h0040;
    step();
    checks++; if (gnt_v !== 4'b1000) begin errors++; $display("FAIL rm_gnt4: got %b expected 1000", gnt_v); end
    req_d[3] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || rvalid_v !== 4'b0000) begin errors++; $display("FAIL rm_abort: got busy %b rvalid %b expected 0 0000", bus.busy, rvalid_v); end
    step();
    checks++; if (rvalid_v !== 4'b0000) begin errors++; $display("FAIL rm_no_rvalid: got %b expected 0000", rvalid_v); end
    req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 16'h0040;
    req_d[3] = 1'b1;
    rst_n = 1'b1;
    step();
    checks++; if (gnt_v !== 4'b0001) begin errors++; $display("FAIL rm_gnt1_first: got %b expected 0001", gnt_v); end
    req_d[0] = 1'b0;
    step();
    step();
    checks++; if (rvalid_v !== 4'b0001 || rdata_a[0] !== 16'h7777) begin errors++; $display("FAIL rm_read1: got rvalid %b rdata %h expected 0001 7777", rvalid_v, rdata_a[0]); end
    step();
    checks++; if (gnt_v !== 4'b1000) begin errors++; $display("FAIL rm_gnt4_next: got %b expected 1000", gnt_v); end
    clear_inputs();
    apply_reset();
    req_d[1] = 1'b1; we_d[1] = 1'b1; addr_d[1] = 16'h0050; data_d[1] = 16'h9999;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL rm_we_drop: got %b expected 0", bus.mem_write_en); end
    clear_inputs();
    step();
    checks++; if ((tbmem.exists(16'h0050) ? tbmem[16'h0050] : 16'h0000) !== 16'h0000) begin errors++; $display("FAIL rm_no_write: got %h expected 0000", tbmem[16'h0050]); end
    rst_n = 1'b1;
    step();
  endtask

  // Reference model: a round-robin choice over the requesting cores, a free-slot
  // countdown (2 cycles per write, 3 per read) and an ordered shadow memory.
  task automatic test_random();
    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] exp_rdata [4];
    int   last, wait_edges, cyc, pend_cyc, pend_core;
    logic [15:0] pend_data;
    logic [3:0]  nxt_gnt, exp_rv;
    logic        nxt_we;
    logic [15:0] nxt_addr, nxt_data;
    clear_inputs();
    apply_reset();
    for (int i = 0; i < 4; i++) exp_rdata[i] = 16'h0000;
    last = 3; wait_edges = 0; cyc = 0; pend_cyc = -1; pend_core = 0; pend_data = 16'h0000;
    for (int n = 0; n < 800; n++) begin
      nxt_gnt = 4'b0000; nxt_we = 1'b0; nxt_addr = 16'h0000; nxt_data = 16'h0000;
      if (wait_edges > 0) begin
        wait_edges--;
      end else if (!load_mode_d && (req_d[0] || req_d[1] || req_d[2] || req_d[3])) begin
        int w;
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && req_d[(last + k) % 4]) w = (last + k) % 4;
        last = w;
        nxt_gnt[w] = 1'b1;
        nxt_we = we_d[w];
        nxt_addr = addr_d[w];
        nxt_data = data_d[w];
        if (we_d[w]) begin
          model_mem[addr_d[w]] = data_d[w];
          wait_edges = 1;
        end else begin
          pend_cyc  = cyc + 3;
          pend_core = w;
          pend_data = model_mem.exists(addr_d[w]) ? model_mem[addr_d[w]] : 16'h0000;
          wait_edges = 2;
        end
      end
      step();
      cyc++;
      exp_rv = 4'b0000;
      if (pend_cyc == cyc) begin
        exp_rv[pend_core] = 1'b1;
        exp_rdata[pend_core] = pend_data;
      end
      checks++; if (gnt_v !== nxt_gnt) begin errors++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", cyc, gnt_v, nxt_gnt); end
      checks++; if (rvalid_v !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cyc %0d: got %b expected %b", cyc, rvalid_v, exp_rv); end
      checks++; if (bus.mem_write_en !== nxt_we) begin errors++; $display("FAIL rnd_mem_we cyc %0d: got %b expected %b", cyc, bus.mem_write_en, nxt_we); end
      if (nxt_gnt != 4'b0000) begin
        checks++; if (bus.mem_addr !== nxt_addr || (nxt_we && bus.mem_data_in !== nxt_data)) begin errors++; $display("FAIL rnd_port cyc %0d: got addr %h data %h expected %h %h", cyc, bus.mem_addr, bus.mem_data_in, nxt_addr, nxt_data); end
      end
      for (int i = 0; i < 4; i++) begin
        checks++; if (rdata_a[i] !== exp_rdata[i]) begin errors++; $display("FAIL rnd_rdata%0d cyc %0d: got %h expected %h", i + 1, cyc, rdata_a[i], exp_rdata[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        if (nxt_gnt[i] || !req_d[i]) begin
          if ((nxt_gnt[i] && $urandom_range(0, 1) == 0) || (!nxt_gnt[i] && $urandom_range(0, 3) == 0)) begin
            req_d[i]  = 1'b1;
            we_d[i]   = 1'($urandom_range(0, 1));
            addr_d[i] = 16'h0100 + 16'($urandom_range(0, 15));
            data_d[i] = 16'($urandom);
          end else begin
            req_d[i] = 1'b0;
          end
        end
      end
      if ($urandom_range(0, 19) == 0) load_mode_d = !load_mode_d;
    end
    clear_inputs();
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    we_count = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_load_mode();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
